mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single `Memory` instance between two requesters, for example the core's fetch and data paths, or the core and a debug/DMA master. It sits between the requesters and the memory. It serialises their transactions through a three-state FSM and drives exactly one memory enable pulse per transaction. It returns read data with a one-cycle acknowledge to the requester that owns the grant.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of all address buses.
- `DATA_WIDTH`, 32, width of all data buses.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req0_i` / `req1_i`  in  1  request from port 0 / port 1.
- `we0_i` / `we1_i`  in  1  1 = write, 0 = read.
- `addr0_i` / `addr1_i`  in  `ADDR_WIDTH`  transaction address.
- `wdata0_i` / `wdata1_i`  in  `DATA_WIDTH`  write data.
- `ack0_o` / `ack1_o`  out  1  one-cycle completion pulse.
- `rdata0_o` / `rdata1_o`  out  `DATA_WIDTH`  read data; valid while the matching ack is high, then held.
- `mem_rd_en_o`  out  1  memory read enable.
- `mem_wr_en_o`  out  1  memory write enable.
- `mem_addr_o`  out  `ADDR_WIDTH`  memory address.
- `mem_data_o`  out  `DATA_WIDTH`  memory write data.
- `mem_data_i`  in  `DATA_WIDTH`  memory read data.
- `mem_ack_i`  in  1  memory completion.

## Operation
- All outputs are registered.
- FSM has three states: IDLE, ISSUE, WAIT.

IDLE:
- A port is eligible when its req is high and its own ack is low in this cycle. The ack-low condition prevents the still-held req from being reissued in the cycle its ack is visible.
- If no port is eligible, stay in IDLE.
- Otherwise select the winner, per Configuration. Latch the winner's we, addr and wdata, record it as `grant`, and go to ISSUE.

ISSUE:
- For exactly one cycle, drive `mem_rd_en_o = !we` and `mem_wr_en_o = we`.
- `mem_addr_o` and `mem_data_o` carry the latched values.
- Go to WAIT.

WAIT:
- Both enables are 0. `mem_addr_o` and `mem_data_o` hold their values.
- On a rising edge with `mem_ack_i = 1`:
  - on a read, capture `mem_data_i` into `rdata<grant>_o`;
  - set `ack<grant>_o = 1` for the next cycle;
  - update `last_grant = grant`;
  - go to IDLE.
- There is no timeout; WAIT holds until `mem_ack_i`.

Data and requester rules:
- A write does not modify `rdataN_o`.
- The non-granted port's ack and rdata are never touched.
- Requester contract: hold req, we, addr and wdata stable until ack. Inputs are sampled only in IDLE. Dropping req after the grant does not cancel the transaction; it completes and acks.
- Address and data pass through unchanged. There is no width conversion and no byte-enables.

## Timing
- Latency from req sampled in IDLE at edge k:
  - mem enable is high in cycle k+1;
  - with a memory that acks one cycle after the enable, `mem_ack_i` is sampled at edge k+2;
  - `ackN_o` is high in cycle k+3.
- Back-to-back throughput is one transaction per 4 cycles: IDLE, ISSUE, WAIT, plus the ack/IDLE cycle.
- A `mem_ack_i` seen in IDLE or ISSUE is ignored.
- Reset values (`rst_n` low at an edge):
  - state = IDLE;
  - `mem_rd_en_o`, `mem_wr_en_o`, `ack0_o`, `ack1_o` = 0;
  - `mem_addr_o`, `mem_data_o`, `rdata0_o`, `rdata1_o` = 0;
  - `grant` = 0, `last_grant` = 1, so port 0 wins the first tie.
- Reset mid-transaction, in ISSUE or WAIT: the transaction is discarded, no ack is issued, and any later `mem_ack_i` is ignored in IDLE.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie, the port other than `last_grant` wins. A single requester always wins regardless of `last_grant`.
- Not defined: fixed priority, port 0 always wins ties. `last_grant` is still maintained but unused for selection.

## Test plan
- Port 0 read of address 0x10 holding 0xDEADBEEF, memory acks one cycle after the enable: `mem_rd_en_o` pulses once in cycle k+1, `ack0_o` is high in cycle k+3 with `rdata0_o = 0xDEADBEEF`, and `ack1_o` stays 0.
- Port 1 write of 0x12345678 to 0x20, then port 1 read of 0x20: `mem_wr_en_o` pulses once; the read returns 0x12345678 on `rdata1_o`; `rdata0_o` is unchanged.
- With the macro defined, both ports hold req continuously for 4 transactions: grants go 0, 1, 0, 1, with exactly 4 enable pulses and 4 acks.
- Macro undefined, same stimulus: port 0 receives all acks while it holds req; port 1 is served only after port 0 drops req.
- Single port holds req through its ack and drops it the cycle after: exactly one memory enable pulse, no duplicate transaction.
- `rst_n` low for one edge while in WAIT: no ack is issued; the late `mem_ack_i` is ignored; the next request completes normally with port 0 winning a tie.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundle of the two requester ports and the memory-side bus of
//            mem_arbiter.
// Ports    : req/we/addr/wdata per requester (in to arbiter),
//            ack/rdata per requester (out of arbiter),
//            mem_rd_en/mem_wr_en/mem_addr/mem_data (out to memory),
//            mem_data_i/mem_ack_i (in from memory).
// Modports : slave  - the arbiter itself
//            master - the environment (requesters + memory)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0_i;
  logic                  req1_i;
  logic                  we0_i;
  logic                  we1_i;
  logic [ADDR_WIDTH-1:0] addr0_i;
  logic [ADDR_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic                  ack0_o;
  logic                  ack1_o;
  logic [DATA_WIDTH-1:0] rdata0_o;
  logic [DATA_WIDTH-1:0] rdata1_o;
  logic                  mem_rd_en_o;
  logic                  mem_wr_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic                  mem_ack_i;

  modport slave (
    input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  mem_data_i, mem_ack_i,
    output ack0_o, ack1_o, rdata0_o, rdata1_o,
    output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output mem_data_i, mem_ack_i,
    input  ack0_o, ack1_o, rdata0_o, rdata1_o,
    input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port arbiter sharing one memory. Transactions are serialised
//            through IDLE -> ISSUE -> WAIT; exactly one memory enable pulse is
//            issued per transaction and a one-cycle ack (with read data) is
//            returned to the granted requester. All outputs are registered.
// Ports    : clk   - system clock, rising edge
//            rst_n - synchronous active-low reset
//            bus   - mem_arbiter_if.slave (requester ports + memory bus)
// Config   : MEM_ARB_ROUND_ROBIN_EN defined -> ties go to the port that did
//            not win last; undefined -> fixed priority, port 0 wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mem_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_grant;
  logic                  r_last_grant;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rd_en;
  logic                  r_wr_en;
  logic                  r_ack0;
  logic                  r_ack1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_start;
  logic                  w_tie_win;
  logic                  w_win;

  // --------------------------------------------------------------------------
  // Next-state and arbitration
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_elig0     = bus.req0_i & ~r_ack0;
    w_elig1     = bus.req1_i & ~r_ack1;
    w_start     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w_tie_win   = ~r_last_grant;
`else
    // last_grant is tracked but never steers a fixed-priority tie.
    w_tie_win   = r_last_grant & 1'b0;
`endif
    // A lone requester always wins; only a tie consults the policy.
    w_win       = (w_elig0 & w_elig1) ? w_tie_win : w_elig1;

    case (r_state)
      S_IDLE: begin
        // The cycle in which an ack is visible closes the previous
        // transaction; no new grant starts in it, which keeps back-to-back
        // traffic at one transaction per four cycles.
        w_start = (w_elig0 | w_elig1) & ~(r_ack0 | r_ack1);
        if (w_start) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.mem_ack_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      // Enables and acks are single-cycle pulses.
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_grant <= w_win;
            r_we    <= w_win ? bus.we1_i    : bus.we0_i;
            r_addr  <= w_win ? bus.addr1_i  : bus.addr0_i;
            r_wdata <= w_win ? bus.wdata1_i : bus.wdata0_i;
            // Registered here so the enable is high exactly in ISSUE.
            r_rd_en <= w_win ? ~bus.we1_i : ~bus.we0_i;
            r_wr_en <= w_win ?  bus.we1_i :  bus.we0_i;
          end
        end
        S_WAIT: begin
          if (bus.mem_ack_i) begin
            if (!r_we) begin
              if (r_grant) r_rdata1 <= bus.mem_data_i;
              else         r_rdata0 <= bus.mem_data_i;
            end
            if (r_grant) r_ack1 <= 1'b1;
            else         r_ack0 <= 1'b1;
            r_last_grant <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_en_o = r_rd_en;
  assign bus.mem_wr_en_o = r_wr_en;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_data_o  = r_wdata;
  assign bus.ack0_o      = r_ack0;
  assign bus.ack1_o      = r_ack1;
  assign bus.rdata0_o    = r_rdata0;
  assign bus.rdata1_o    = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. A small memory
//            model acks one cycle after each enable (auto mode) or only when
//            the bench pulses man_ack (manual mode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  logic        mem_rst;
  logic        auto_en;
  logic        man_ack;
  logic        model_ack;
  logic [31:0] model_data;

  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      model_ack  <= 1'b0;
      model_data <= 32'h0;
    end else begin
      model_ack <= auto_en & (bus.mem_rd_en_o | bus.mem_wr_en_o);
      if (bus.mem_wr_en_o) mem[bus.mem_addr_o[7:0]] <= bus.mem_data_o;
      if (bus.mem_rd_en_o) model_data <= mem[bus.mem_addr_o[7:0]];
    end
  end

  assign bus.mem_ack_i  = model_ack | man_ack;
  assign bus.mem_data_i = model_data;

  // ---------------- event counters ----------------
  int rd_cnt = 0, wr_cnt = 0, a0_cnt = 0, a1_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_rd_en_o === 1'b1) rd_cnt++;
    if (bus.mem_wr_en_o === 1'b1) wr_cnt++;
    if (bus.ack0_o === 1'b1) a0_cnt++;
    if (bus.ack1_o === 1'b1) a1_cnt++;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_en"}, bus.mem_rd_en_o, 0);
    chk({tag, "_wr_en"}, bus.mem_wr_en_o, 0);
    chk({tag, "_ack0"},  bus.ack0_o, 0);
    chk({tag, "_ack1"},  bus.ack1_o, 0);
    chk({tag, "_addr"},  bus.mem_addr_o, 0);
    chk({tag, "_data"},  bus.mem_data_o, 0);
    chk({tag, "_rdata0"}, bus.rdata0_o, 0);
    chk({tag, "_rdata1"}, bus.rdata1_o, 0);
  endtask

  // Step until the given port acks; an expired budget is a failed check.
  task automatic wait_ack(input string tag, input int port);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step(1);
      if ((port == 0 && bus.ack0_o === 1'b1) || (port == 1 && bus.ack1_o === 1'b1))
        seen = 1'b1;
    end
    chk({tag, "_ack_seen"}, seen, 1);
  endtask

  int b_rd, b_wr, b_a0, b_a1;
  task automatic base();
    b_rd = rd_cnt; b_wr = wr_cnt; b_a0 = a0_cnt; b_a1 = a1_cnt;
  endtask

  logic got [0:7];
  logic exp_order [0:7];
  int   n_got;
  int   n_exp;
  bit   seen_any;

  initial begin
    bus.req0_i = 0; bus.we0_i = 0; bus.addr0_i = '0; bus.wdata0_i = '0;
    bus.req1_i = 0; bus.we1_i = 0; bus.addr1_i = '0; bus.wdata1_i = '0;
    mem_rst = 1; auto_en = 1; man_ack = 0;

    // Reset state
    step(3);
    mem_rst = 0;
    chk_reset("reset");
    rst_n = 1;
    step(1);

    // Port 0 read of 0x10, cycle-exact latency
    base();
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 32'h10;
    step(1);
    chk("t1_rd_en_k1", bus.mem_rd_en_o, 1);
    chk("t1_wr_en_k1", bus.mem_wr_en_o, 0);
    chk("t1_addr", bus.mem_addr_o, 32'h10);
    step(1);
    chk("t1_rd_en_k2", bus.mem_rd_en_o, 0);
    chk("t1_ack0_k2", bus.ack0_o, 0);
    step(1);
    chk("t1_ack0_k3", bus.ack0_o, 1);
    chk("t1_rdata0", bus.rdata0_o, 32'hDEADBEEF);
    chk("t1_ack1", bus.ack1_o, 0);
    bus.req0_i = 0;
    step(3);
    chk("t1_rd_pulses", rd_cnt - b_rd, 1);
    chk("t1_ack0_cnt", a0_cnt - b_a0, 1);
    chk("t1_ack1_cnt", a1_cnt - b_a1, 0);

    // Port 1 write of 0x12345678 to 0x20, then read it back
    base();
    bus.req1_i = 1; bus.we1_i = 1; bus.addr1_i = 32'h20; bus.wdata1_i = 32'h12345678;
    wait_ack("t2w", 1);
    chk("t2w_mem_data", bus.mem_data_o, 32'h12345678);
    bus.req1_i = 0;
    step(2);
    chk("t2w_wr_pulses", wr_cnt - b_wr, 1);
    chk("t2w_rd_pulses", rd_cnt - b_rd, 0);
    chk("t2w_rdata1_kept", bus.rdata1_o, 0);
    chk("t2w_rdata0_kept", bus.rdata0_o, 32'hDEADBEEF);
    bus.we1_i = 0; bus.req1_i = 1;
    wait_ack("t2r", 1);
    chk("t2r_rdata1", bus.rdata1_o, 32'h12345678);
    bus.req1_i = 0;
    step(2);
    chk("t2r_rdata0_kept", bus.rdata0_o, 32'hDEADBEEF);
    chk("t2r_ack0_cnt", a0_cnt - b_a0, 0);

    // Both ports hold req continuously
    base();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    n_exp = 4;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
    n_exp = 5;
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
    exp_order[4] = 1;
`endif
    n_got = 0;
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 32'h10;
    bus.req1_i = 1; bus.we1_i = 0; bus.addr1_i = 32'h20;
    for (int c = 0; c < 80 && n_got < n_exp; c++) begin
      step(1);
      if (bus.ack0_o === 1'b1 || bus.ack1_o === 1'b1) begin
        got[n_got] = bus.ack1_o;
        n_got++;
        if (n_got == 4) begin
          bus.req0_i = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          bus.req1_i = 0;
`endif
        end
        if (n_got == 5) bus.req1_i = 0;
      end
    end
    bus.req0_i = 0; bus.req1_i = 0;
    step(4);
    chk("t3_ack_count", n_got, n_exp);
    for (int i = 0; i < n_got; i++) chk($sformatf("t3_grant%0d", i), got[i], exp_order[i]);
    chk("t3_rd_pulses", rd_cnt - b_rd, n_exp);
    chk("t3_total_acks", (a0_cnt - b_a0) + (a1_cnt - b_a1), n_exp);

    // Single port holds req through its ack, drops it the cycle after
    base();
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 32'h20;
    wait_ack("t4", 0);
    step(1);
    bus.req0_i = 0;
    step(4);
    chk("t4_rd_pulses", rd_cnt - b_rd, 1);
    chk("t4_ack0_cnt", a0_cnt - b_a0, 1);
    chk("t4_rdata0", bus.rdata0_o, 32'h12345678);

    // Manual memory ack: ack in ISSUE ignored, WAIT holds until ack
    auto_en = 0;
    base();
    bus.req1_i = 1; bus.we1_i = 0; bus.addr1_i = 32'h10;
    step(1);
    man_ack = 1;
    step(1);
    man_ack = 0;
    step(4);
    chk("t5_no_early_ack", a1_cnt - b_a1, 0);
    chk("t5_one_pulse", rd_cnt - b_rd, 1);
    man_ack = 1;
    step(1);
    man_ack = 0;
    chk("t5_ack1", bus.ack1_o, 1);
    chk("t5_rdata1", bus.rdata1_o, 32'hDEADBEEF);
    bus.req1_i = 0;
    step(2);

    // Reset while in WAIT
    base();
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 32'h10;
    step(2);
    rst_n = 0; bus.req0_i = 0;
    step(1);
    rst_n = 1;
    chk_reset("t6_rst");
    man_ack = 1;
    step(1);
    man_ack = 0;
    step(3);
    chk("t6_no_ack0", a0_cnt - b_a0, 0);
    chk("t6_no_ack1", a1_cnt - b_a1, 0);
    chk("t6_rd_pulses", rd_cnt - b_rd, 1);
    chk("t6_idle_rd_en", bus.mem_rd_en_o, 0);
    auto_en = 1;
    bus.req0_i = 1; bus.we0_i = 0; bus.addr0_i = 32'h10;
    bus.req1_i = 1; bus.we1_i = 0; bus.addr1_i = 32'h20;
    seen_any = 0;
    for (int c = 0; c < 30 && !seen_any; c++) begin
      step(1);
      if (bus.ack0_o === 1'b1 || bus.ack1_o === 1'b1) seen_any = 1;
    end
    chk("t6_ack_seen", seen_any, 1);
    chk("t6_ack0_first", bus.ack0_o, 1);
    chk("t6_ack1_first", bus.ack1_o, 0);
    chk("t6_rdata0", bus.rdata0_o, 32'hDEADBEEF);
    bus.req0_i = 0; bus.req1_i = 0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
